// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point co-processor datapath blocks.
package fpu_pkg;

    localparam int unsigned FPU_ADDR_W     = 8;
    localparam int unsigned FPU_DATA_W     = 32;
    localparam int unsigned FPU_SEL_W      = 4;
    localparam int unsigned MAX_RD_LATENCY = 7;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        WRITE
    } load_state_t;

endpackage

// File: rtl/load.sv
// Load unit: reads one word from the operand SRAM and writes it into the
// selected register-file entry, then pulses done. Every output is either a
// register or a decode of the state register.
module load
    import fpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = FPU_ADDR_W,
    parameter int unsigned DATA_W     = FPU_DATA_W,
    parameter int unsigned SEL_W      = FPU_SEL_W,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              en,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [SEL_W-1:0]  dest_sel,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [ADDR_W-1:0] out_addr,
    output logic              r_en,
    output logic [DATA_W-1:0] reg_data,
    output logic [SEL_W-1:0]  reg_sel,
    output logic              reg_w_en,
    output logic              done,
    output logic              busy
);

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("load: RD_LATENCY must be in 1..%0d", MAX_RD_LATENCY);
    end

    // WAIT covers RD_LATENCY-1 cycles so that CAPTURE lands RD_LATENCY
    // cycles after ISSUE.
    localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

    load_state_t       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  reg_sel_q, reg_sel_d;

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            reg_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            reg_sel_q <= reg_sel_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        data_d    = data_q;
        reg_sel_d = reg_sel_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    addr_d  = sram_addr;
                    sel_d   = dest_sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (RD_LATENCY > 1) begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end else begin
                    state_d = CAPTURE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // reg_sel is updated together with the data so both outputs
                // change only when the write is presented.
                data_d    = sram_rdata;
                reg_sel_d = sel_q;
                state_d   = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state or taken straight from registers.
    always_comb begin
        out_addr = addr_q;
        reg_data = data_q;
        reg_sel  = reg_sel_q;
        r_en     = (state_q == ISSUE);
        reg_w_en = (state_q == WRITE);
        done     = (state_q == WRITE);
        busy     = (state_q != IDLE);
    end

endmodule

// File: tb/tb_load.sv
// Bench for the load unit: three instances (RD_LATENCY 2, 1, 7) share the
// stimulus; each has its own SRAM model and expected-transaction queue.
module tb_load;

    typedef struct {
        int          e;
        logic [7:0]  addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } txn_t;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 7);
    endfunction

    function automatic logic [31:0] mem(input logic [7:0] a);
        case (a)
            8'h3C:   return 32'h3F800000;
            8'hFF:   return 32'hC0490FDB;
            default: return {8'h40, a, ~a, a ^ 8'h5A};
        endcase
    endfunction

    logic        clk;
    logic        nRst;
    logic        en;
    logic [7:0]  sram_addr;
    logic [3:0]  dest_sel;

    logic [31:0] sram_rdata [3];
    logic [7:0]  out_addr   [3];
    logic        r_en       [3];
    logic [31:0] reg_data   [3];
    logic [3:0]  reg_sel    [3];
    logic        reg_w_en   [3];
    logic        done       [3];
    logic        busy       [3];

    int          cyc;
    int          n_checks;
    int          n_errors;
    int          free_at   [3];
    logic [31:0] last_data [3];
    logic [3:0]  last_sel  [3];
    txn_t        sb        [3][$];

    logic        pv [3][8];
    logic [7:0]  pa [3][8];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        load #(
            .RD_LATENCY(lat_of(g))
        ) u_dut (
            .clk        (clk),
            .nRst       (nRst),
            .en         (en),
            .sram_addr  (sram_addr),
            .dest_sel   (dest_sel),
            .sram_rdata (sram_rdata[g]),
            .out_addr   (out_addr[g]),
            .r_en       (r_en[g]),
            .reg_data   (reg_data[g]),
            .reg_sel    (reg_sel[g]),
            .reg_w_en   (reg_w_en[g]),
            .done       (done[g]),
            .busy       (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: the correct word appears only in the cycle exactly
    // RD_LATENCY cycles after r_en; every other cycle carries junk.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 7; k > 0; k--) begin
                pv[i][k] <= pv[i][k-1];
                pa[i][k] <= pa[i][k-1];
            end
            pv[i][0] <= r_en[i];
            pa[i][0] <= out_addr[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sram_rdata[i] = 32'hBAD00000 ^ 32'(cyc);
            if (pv[i][lat_of(i)-1]) begin
                sram_rdata[i] = mem(pa[i][lat_of(i)-1]);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string when);
        for (int i = 0; i < 3; i++) begin
            string p;
            p = $sformatf("L%0d %s", lat_of(i), when);
            check_eq({p, " out_addr"}, 32'(out_addr[i]), '0);
            check_eq({p, " r_en"},     32'(r_en[i]),     '0);
            check_eq({p, " reg_data"}, reg_data[i],      '0);
            check_eq({p, " reg_sel"},  32'(reg_sel[i]),  '0);
            check_eq({p, " reg_w_en"}, 32'(reg_w_en[i]), '0);
            check_eq({p, " done"},     32'(done[i]),     '0);
            check_eq({p, " busy"},     32'(busy[i]),     '0);
        end
    endtask

    // Drive one cycle of stimulus; queue an expected load for every instance
    // that is idle in this cycle by the bench's own timing model.
    task automatic drive(input logic e, input logic [7:0] a, input logic [3:0] s);
        @(posedge clk);
        #1;
        en        = e;
        sram_addr = a;
        dest_sel  = s;
        if (e && nRst) begin
            for (int i = 0; i < 3; i++) begin
                if (cyc >= free_at[i]) begin
                    txn_t t;
                    t.e    = cyc;
                    t.addr = a;
                    t.sel  = s;
                    t.data = mem(a);
                    sb[i].push_back(t);
                    free_at[i] = cyc + 3 + lat_of(i);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, sram_addr, dest_sel);
        end
    endtask

    // Per-cycle monitor: compares outputs against the head of each queue and
    // retires an entry when its write cycle is reached.
    always @(negedge clk) begin
        if (nRst) begin
            for (int i = 0; i < 3; i++) begin
                int    l;
                int    e;
                logic  act;
                txn_t  t;
                string p;
                l = lat_of(i);
                p = $sformatf("L%0d", l);
                if (sb[i].size() > 0) begin
                    t   = sb[i][0];
                    e   = t.e;
                    act = (cyc >= e + 1) && (cyc <= e + 2 + l);
                    check_eq({p, " busy"},     32'(busy[i]),     32'(act));
                    check_eq({p, " r_en"},     32'(r_en[i]),     32'(cyc == e + 1));
                    check_eq({p, " reg_w_en"}, 32'(reg_w_en[i]), 32'(cyc == e + 2 + l));
                    check_eq({p, " done"},     32'(done[i]),     32'(cyc == e + 2 + l));
                    if (act && cyc <= e + 1 + l) begin
                        check_eq({p, " out_addr"}, 32'(out_addr[i]), 32'(t.addr));
                    end
                    if (cyc >= e + 2 + l) begin
                        check_eq({p, " reg_data"}, reg_data[i],     t.data);
                        check_eq({p, " reg_sel"},  32'(reg_sel[i]), 32'(t.sel));
                        last_data[i] = t.data;
                        last_sel[i]  = t.sel;
                        void'(sb[i].pop_front());
                    end else begin
                        check_eq({p, " reg_data hold"}, reg_data[i],     last_data[i]);
                        check_eq({p, " reg_sel hold"},  32'(reg_sel[i]), 32'(last_sel[i]));
                    end
                end else begin
                    check_eq({p, " busy idle"},     32'(busy[i]),     '0);
                    check_eq({p, " r_en idle"},     32'(r_en[i]),     '0);
                    check_eq({p, " reg_w_en idle"}, 32'(reg_w_en[i]), '0);
                    check_eq({p, " done idle"},     32'(done[i]),     '0);
                    check_eq({p, " reg_data hold"}, reg_data[i],      last_data[i]);
                    check_eq({p, " reg_sel hold"},  32'(reg_sel[i]),  32'(last_sel[i]));
                end
            end
        end
    end

    initial begin
        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        en        = 1'b0;
        sram_addr = 8'h00;
        dest_sel  = 4'h0;
        for (int i = 0; i < 3; i++) begin
            free_at[i]   = 0;
            last_data[i] = '0;
            last_sel[i]  = '0;
            for (int k = 0; k < 8; k++) begin
                pv[i][k] = 1'b0;
                pa[i][k] = 8'h00;
            end
        end
        nRst = 1'b1;
        #1;
        nRst = 1'b0;
        #1;
        check_all_zero("reset");
        idle(2);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        idle(2);

        // Basic load, then en held high with new inputs: tests mid-flight
        // input changes and back-to-back acceptance right after WRITE.
        drive(1'b1, 8'h3C, 4'h5);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 8'hFF, 4'hF);
        end
        idle(12);

        // Single load with inputs scrambled during the transaction.
        drive(1'b1, 8'h12, 4'h3);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 8'($urandom), 4'($urandom));
        end
        idle(12);

        // Reset in the middle of a load: outputs must clear at once and the
        // aborted load must never complete.
        drive(1'b1, 8'h77, 4'h9);
        drive(1'b0, 8'h00, 4'h0);
        @(posedge clk);
        #1;
        nRst = 1'b0;
        #1;
        check_all_zero("mid-op reset");
        for (int i = 0; i < 3; i++) begin
            sb[i].delete();
            free_at[i]   = 0;
            last_data[i] = '0;
            last_sel[i]  = '0;
        end
        idle(2);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        idle(12);
        drive(1'b1, 8'h80, 4'hA);
        idle(12);

        // Assorted loads including both address extremes and varied spacing.
        for (int n = 0; n < 8; n++) begin
            logic [7:0] a;
            a = (n == 0) ? 8'h00 : ((n == 1) ? 8'hFF : 8'($urandom));
            idle($urandom_range(0, 4));
            drive(1'b1, a, 4'($urandom));
            drive(1'b0, 8'($urandom), 4'($urandom));
        end
        idle(15);

        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("L%0d all loads completed", lat_of(i)), 32'(sb[i].size()), '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
